float_adder_pipe_param: RTL and testbench



---
 rtl/float_adder_pipe_param.sv | 208 ++++++++++++++++++++
 tb/tb_float_adder_pipe_param.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/float_adder_pipe_param.sv
// Sign-magnitude float adder with configurable EXP_W/MAN_W, sequenced as align/add/normalise/round.
// Build option FLOAT_ADDER_RNE_EN selects round-to-nearest-even; without it results are truncated.
module float_adder_pipe_param #(
  parameter int EXP_W = 4,
  parameter int MAN_W = 3
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [EXP_W+MAN_W:0]   y,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   overflow,
  output logic                   underflow
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int WM = MAN_W + 5;
  localparam int XW = EXP_W + 2;
  localparam logic [XW-1:0] EMAX = {2'b00, {EXP_W{1'b1}}};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ALIGN = 3'd1,
    ADD   = 3'd2,
    NORM  = 3'd3,
    ROUND = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d, y_q, y_d;
  logic [WM-1:0] m_q, m_d, my_q, my_d;
  logic [XW-1:0] exp_q, exp_d;
  logic          sign_q, sign_d, sub_q, sub_d, zero_q, zero_d, flush_q, flush_d;
  logic          in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic          ovf_q, ovf_d, unf_q, unf_d;

  logic             a_big_s, inc_s;
  logic [W-1:0]     x_s, v_s;
  logic [EXP_W-1:0] ex_s, ey_s, d_s;
  logic [WM-1:0]    fx_s, fy_s, fy_sh_s, lost_s;
  logic [MAN_W+1:0] mr_s;
  logic [XW-1:0]    er_s;

  // Operand ordering, alignment shift and rounding increment
  always_comb begin
    a_big_s = (a_q[W-2:0] >= b_q[W-2:0]);
    x_s     = a_big_s ? a_q : b_q;
    v_s     = a_big_s ? b_q : a_q;
    ex_s    = x_s[W-2:MAN_W];
    ey_s    = v_s[W-2:MAN_W];
    d_s     = ex_s - ey_s;
    // A zero exponent field means zero, so its working mantissa has no hidden bit
    fx_s    = (ex_s != {EXP_W{1'b0}}) ? {2'b01, x_s[MAN_W-1:0], 3'b000} : {WM{1'b0}};
    fy_s    = (ey_s != {EXP_W{1'b0}}) ? {2'b01, v_s[MAN_W-1:0], 3'b000} : {WM{1'b0}};
    lost_s  = fy_s & ~({WM{1'b1}} << d_s);
    if (32'(d_s) > 32'(MAN_W + 3)) begin
      fy_sh_s = {{(WM-1){1'b0}}, |fy_s};
    end else begin
      fy_sh_s = (fy_s >> d_s) | {{(WM-1){1'b0}}, |lost_s};
    end
`ifdef FLOAT_ADDER_RNE_EN
    inc_s = m_q[2] & (m_q[1] | m_q[0] | m_q[3]);
`else
    inc_s = 1'b0;
`endif
    mr_s = {1'b0, m_q[WM-2:3]} + {{(MAN_W+1){1'b0}}, inc_s};
    er_s = exp_q + {{(XW-1){1'b0}}, mr_s[MAN_W+1]};
  end

  // Next-state and datapath updates for the operation sequencer
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    y_d     = y_q;
    m_d     = m_q;
    my_d    = my_q;
    exp_d   = exp_q;
    sign_d  = sign_q;
    sub_d   = sub_q;
    zero_d  = zero_q;
    flush_d = flush_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d     = a;
          b_d     = b;
          zero_d  = 1'b0;
          flush_d = 1'b0;
          state_d = ALIGN;
        end else begin
          state_d = IDLE;
        end
      end
      ALIGN: begin
        m_d     = fx_s;
        my_d    = fy_sh_s;
        exp_d   = {2'b00, ex_s};
        sign_d  = x_s[W-1];
        sub_d   = x_s[W-1] ^ v_s[W-1];
        state_d = ADD;
      end
      ADD: begin
        m_d     = sub_q ? (m_q - my_q) : (m_q + my_q);
        state_d = NORM;
      end
      NORM: begin
        // After a carry shift the hidden bit is set, so no further normalisation is needed
        if (m_q[WM-1]) begin
          m_d     = {1'b0, m_q[WM-1:2], m_q[1] | m_q[0]};
          exp_d   = exp_q + {{(XW-1){1'b0}}, 1'b1};
          state_d = ROUND;
        end else if (m_q == {WM{1'b0}}) begin
          zero_d  = 1'b1;
          state_d = ROUND;
        end else if (!m_q[WM-2]) begin
          if (exp_q == {{(XW-1){1'b0}}, 1'b1}) begin
            zero_d  = 1'b1;
            flush_d = 1'b1;
            state_d = ROUND;
          end else begin
            m_d   = {m_q[WM-2:0], 1'b0};
            exp_d = exp_q - {{(XW-1){1'b0}}, 1'b1};
          end
        end else begin
          state_d = ROUND;
        end
      end
      ROUND: begin
        if (zero_q) begin
          y_d   = {W{1'b0}};
          ovf_d = 1'b0;
          unf_d = flush_q;
        end else if (er_s > EMAX) begin
          y_d   = {sign_q, {(W-1){1'b1}}};
          ovf_d = 1'b1;
          unf_d = 1'b0;
        end else begin
          y_d   = {sign_q, er_s[EXP_W-1:0], mr_s[MAN_W+1] ? {MAN_W{1'b0}} : mr_s[MAN_W-1:0]};
          ovf_d = 1'b0;
          unf_d = 1'b0;
        end
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  // State and datapath registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      a_q         <= {W{1'b0}};
      b_q         <= {W{1'b0}};
      y_q         <= {W{1'b0}};
      m_q         <= {WM{1'b0}};
      my_q        <= {WM{1'b0}};
      exp_q       <= {XW{1'b0}};
      sign_q      <= 1'b0;
      sub_q       <= 1'b0;
      zero_q      <= 1'b0;
      flush_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      y_q         <= y_d;
      m_q         <= m_d;
      my_q        <= my_d;
      exp_q       <= exp_d;
      sign_q      <= sign_d;
      sub_q       <= sub_d;
      zero_q      <= zero_d;
      flush_q     <= flush_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
endmodule

// File: tb/tb_float_adder_pipe_param.sv
// Bench for float_adder_pipe_param: e4m3 directed table plus random checks on three parameter sets.
module tb_float_adder_pipe_param;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  int n_vec  = 0;
  int n_miss = 0;
  int EW[3] = '{4, 5, 8};
  int MW[3] = '{3, 2, 7};

  logic [15:0] a_v[3];
  logic [15:0] b_v[3];
  logic        iv_v[3];
  logic        ordy_v[3];
  wire         ir_v[3];
  wire         ov_v[3];
  wire         ovf_v[3];
  wire         unf_v[3];
  wire  [7:0]  y0;
  wire  [7:0]  y1;
  wire  [15:0] y2;

  float_adder_pipe_param #(.EXP_W(4), .MAN_W(3)) dut0 (
    .clock(clock), .reset(reset), .a(a_v[0][7:0]), .b(b_v[0][7:0]), .in_valid(iv_v[0]),
    .in_ready(ir_v[0]), .y(y0), .out_valid(ov_v[0]), .out_ready(ordy_v[0]),
    .overflow(ovf_v[0]), .underflow(unf_v[0]));
  float_adder_pipe_param #(.EXP_W(5), .MAN_W(2)) dut1 (
    .clock(clock), .reset(reset), .a(a_v[1][7:0]), .b(b_v[1][7:0]), .in_valid(iv_v[1]),
    .in_ready(ir_v[1]), .y(y1), .out_valid(ov_v[1]), .out_ready(ordy_v[1]),
    .overflow(ovf_v[1]), .underflow(unf_v[1]));
  float_adder_pipe_param #(.EXP_W(8), .MAN_W(7)) dut2 (
    .clock(clock), .reset(reset), .a(a_v[2]), .b(b_v[2]), .in_valid(iv_v[2]),
    .in_ready(ir_v[2]), .y(y2), .out_valid(ov_v[2]), .out_ready(ordy_v[2]),
    .overflow(ovf_v[2]), .underflow(unf_v[2]));

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] y;
    logic       ov;
    logic       uf;
    int         lat;
  } vec_t;

  function automatic logic [15:0] get_y(input int k);
    case (k)
      0:       return {8'h00, y0};
      1:       return {8'h00, y1};
      default: return y2;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Reference: exact scaled-integer sum, then normalise and round; returns {uf, ov, y}
  function automatic logic [17:0] ref_add(input int E, input int M, input logic [15:0] a,
                                          input logic [15:0] b);
    longint one, emax, ea, eb, ma, mb, sa, sb, ex, ey, mx, my, sx, sy;
    longint d, fx, fy, s, q, rem, half, e;
    int K, p, sh;
    one  = 1;
    emax = (one << E) - 1;
    ea = (longint'(a) >> M) & emax;  ma = longint'(a) & ((one << M) - 1);
    eb = (longint'(b) >> M) & emax;  mb = longint'(b) & ((one << M) - 1);
    sa = (longint'(a) >> (E + M)) & 1;
    sb = (longint'(b) >> (E + M)) & 1;
    if (ea == 0 && eb == 0) return 18'h0;
    if (eb == 0) return {2'b00, a};
    if (ea == 0) return {2'b00, b};
    if (((ea << M) | ma) >= ((eb << M) | mb)) begin
      ex = ea; mx = ma; sx = sa; ey = eb; my = mb; sy = sb;
    end else begin
      ex = eb; mx = mb; sx = sb; ey = ea; my = ma; sy = sa;
    end
    K  = M + 6;
    d  = ex - ey;
    fx = ((one << M) | mx) << K;
    if (d <= K) fy = (((one << M) | my) << K) >> d;
    else        fy = 1;
    s = (sx == sy) ? fx + fy : fx - fy;
    if (s == 0) return 18'h0;
    p = 0;
    for (int i = 0; i < 63; i++) if (((s >> i) & 1) == 1) p = i;
    e = ex + p - (M + K);
    if (e <= 0) return {1'b1, 1'b0, 16'h0000};
    sh   = p - M;
    q    = s >> sh;
    rem  = s & ((one << sh) - 1);
    half = (sh > 0) ? (one << (sh - 1)) : 0;
`ifdef FLOAT_ADDER_RNE_EN
    if (sh > 0 && (rem > half || (rem == half && (q & 1) == 1))) q = q + 1;
`endif
    if (q == (one << (M + 1))) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e > emax) return {1'b0, 1'b1, 16'((sx << (E + M)) | ((one << (E + M)) - 1))};
    return {2'b00, 16'((sx << (E + M)) | (e << M) | (q & ((one << M) - 1)))};
  endfunction

  // Called at a negedge; returns at a negedge after the result handshake
  task automatic run_op(input int k, input logic [15:0] av, input logic [15:0] bv,
                        output logic [15:0] yo, output logic ovo, output logic ufo,
                        output int lat);
    int n;
    n = 0;
    while (!ir_v[k] && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!ir_v[k]) chk("in_ready_wait", {15'h0000, ir_v[k]}, 16'h0001);
    a_v[k]  = av;
    b_v[k]  = bv;
    iv_v[k] = 1'b1;
    @(posedge clock);
    #1 iv_v[k] = 1'b0;
    lat = 1;
    while (lat < 60) begin
      @(negedge clock);
      if (ov_v[k]) break;
      @(posedge clock);
      lat++;
    end
    chk("out_valid_seen", {15'h0000, ov_v[k]}, 16'h0001);
    yo  = get_y(k);
    ovo = ovf_v[k];
    ufo = unf_v[k];
    ordy_v[k] = 1'b1;
    @(posedge clock);
    #1 ordy_v[k] = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    vec_t        tbl[13];
    logic [15:0] ry, av, bv, mask;
    logic [17:0] exp_r;
    logic        rov, ruf, rne_y;
    int          lat, W;

    rne_y = 1'b0;
`ifdef FLOAT_ADDER_RNE_EN
    rne_y = 1'b1;
`endif
    tbl[0]  = '{8'h38, 8'h38, 8'h40, 1'b0, 1'b0, 5};
    tbl[1]  = '{8'h3C, 8'hB8, 8'h30, 1'b0, 1'b0, 6};
    tbl[2]  = '{8'h38, 8'hB8, 8'h00, 1'b0, 1'b0, 5};
    tbl[3]  = '{8'h7F, 8'h7F, 8'h7F, 1'b1, 1'b0, 5};
    tbl[4]  = '{8'h38, 8'h1C, rne_y ? 8'h39 : 8'h38, 1'b0, 1'b0, 5};
    tbl[5]  = '{8'h38, 8'h18, 8'h38, 1'b0, 1'b0, 5};
    tbl[6]  = '{8'h09, 8'h88, 8'h00, 1'b0, 1'b1, 5};
    tbl[7]  = '{8'hC5, 8'h00, 8'hC5, 1'b0, 1'b0, 5};
    tbl[8]  = '{8'h03, 8'h00, 8'h00, 1'b0, 1'b0, 5};
    tbl[9]  = '{8'h05, 8'hB8, 8'hB8, 1'b0, 1'b0, 5};
    tbl[10] = '{8'h40, 8'hBC, 8'h30, 1'b0, 1'b0, 7};
    tbl[11] = '{8'h3F, 8'h3F, 8'h47, 1'b0, 1'b0, 5};
    tbl[12] = '{8'h7F, 8'h3F, 8'h7F, 1'b0, 1'b0, 5};

    for (int k = 0; k < 3; k++) begin
      a_v[k] = 16'h0000; b_v[k] = 16'h0000; iv_v[k] = 1'b0; ordy_v[k] = 1'b0;
    end
    reset = 1'b0;
    #12;
    chk("reset_y", {8'h00, y0}, 16'h0000);
    chk("reset_ctrl", {12'h000, ir_v[0], ov_v[0], ovf_v[0], unf_v[0]}, 16'h0008);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    for (int i = 0; i < 13; i++) begin
      run_op(0, {8'h00, tbl[i].a}, {8'h00, tbl[i].b}, ry, rov, ruf, lat);
      chk($sformatf("tbl%0d_y", i), ry, {8'h00, tbl[i].y});
      chk($sformatf("tbl%0d_flags", i), {14'h0000, rov, ruf}, {14'h0000, tbl[i].ov, tbl[i].uf});
      chk($sformatf("tbl%0d_lat", i), 16'(lat), 16'(tbl[i].lat));
    end

    // Consumer stalls for three cycles in DONE
    a_v[0] = 16'h0038; b_v[0] = 16'h0038; iv_v[0] = 1'b1;
    @(posedge clock);
    #1 iv_v[0] = 1'b0;
    for (int c = 0; c < 20 && !ov_v[0]; c++) @(negedge clock);
    for (int c = 0; c < 3; c++) begin
      chk("stall_ctrl", {12'h000, ov_v[0], ir_v[0], ovf_v[0], unf_v[0]}, 16'h0008);
      chk("stall_y", {8'h00, y0}, 16'h0040);
      @(negedge clock);
    end
    ordy_v[0] = 1'b1;
    @(posedge clock);
    #1 ordy_v[0] = 1'b0;
    @(negedge clock);
    chk("release_ctrl", {14'h0000, ir_v[0], ov_v[0]}, 16'h0002);

    // Asynchronous reset while the operation is normalising
    a_v[0] = 16'h0040; b_v[0] = 16'h00BC; iv_v[0] = 1'b1;
    @(posedge clock);
    #1 iv_v[0] = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #2 reset = 1'b0;
    #1;
    chk("midreset_ctrl", {14'h0000, ir_v[0], ov_v[0]}, 16'h0002);
    chk("midreset_y", {8'h00, y0}, 16'h0000);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    run_op(0, 16'h0038, 16'h0038, ry, rov, ruf, lat);
    chk("after_reset_y", ry, 16'h0040);

    for (int k = 0; k < 3; k++) begin
      W    = 1 + EW[k] + MW[k];
      mask = 16'((32'd1 << W) - 1);
      for (int i = 0; i < 150; i++) begin
        av = 16'($urandom) & mask;
        if ($urandom_range(0, 1) == 1) begin
          bv = 16'($urandom) & mask;
        end else begin
          bv = (av ^ 16'($urandom_range(0, (1 << (MW[k] + 2)) - 1))
                   ^ (16'($urandom_range(0, 1)) << (W - 1))) & mask;
        end
        exp_r = ref_add(EW[k], MW[k], av, bv);
        run_op(k, av, bv, ry, rov, ruf, lat);
        chk($sformatf("rnd_p%0d_%h_%h_y", k, av, bv), ry, exp_r[15:0]);
        chk($sformatf("rnd_p%0d_%h_%h_flags", k, av, bv), {14'h0000, rov, ruf},
            {14'h0000, exp_r[16], exp_r[17]});
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
